// File: rtl/crc_frame_tx.sv
// crc_frame_tx: sends a captured N-byte payload followed by its CRC byte on a ready/valid byte stream.
// Define FRAME_SYNC_EN to send a 0xA5 sync byte at the start of each frame.
module crc_frame_tx #(
   parameter int N = 6
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           crc_done,
   input  logic [7:0]     crc_in,
   input  logic [8*N-1:0] bytes_flat,
   input  logic           tx_ready,
   output logic           tx_valid,
   output logic [7:0]     tx_data,
   output logic           tx_last,
   output logic           busy,
   output logic [7:0]     drop_cnt
);
   localparam int IW = $clog2(N) + 1;
   typedef enum logic [2:0] {IDLE, CAPT, DATA, CRC
`ifdef FRAME_SYNC_EN
      , SYNC
`endif
   } state_t;
   state_t         state;
   logic [IW-1:0]  idx;
   logic [8*N-1:0] pay;
   logic [7:0]     crc_sh;
   logic [7:0]     pay_nxt;
   logic           xfer;
   assign xfer = tx_valid && tx_ready;
   assign busy = state != IDLE;
   // the byte after idx, preloaded into tx_data so transfers run back to back
   assign pay_nxt = 8'(pay >> {idx + IW'(1), 3'b000});
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         idx      <= '0;
         pay      <= '0;
         crc_sh   <= '0;
         tx_valid <= 1'b0;
         tx_data  <= '0;
         tx_last  <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (crc_done && state != IDLE && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
         case (state)
            IDLE: if (crc_done) begin
               pay   <= bytes_flat;
               state <= CAPT;
            end
            CAPT: begin
               crc_sh   <= crc_in;
               idx      <= '0;
               tx_valid <= 1'b1;
`ifdef FRAME_SYNC_EN
               tx_data  <= 8'hA5;
               state    <= SYNC;
`else
               tx_data  <= pay[7:0];
               state    <= DATA;
`endif
            end
`ifdef FRAME_SYNC_EN
            SYNC: if (xfer) begin
               tx_data <= pay[7:0];
               state   <= DATA;
            end
`endif
            DATA: if (xfer) begin
               if (idx == IW'(N - 1)) begin
                  tx_data <= crc_sh;
                  tx_last <= 1'b1;
                  state   <= CRC;
               end else begin
                  idx     <= idx + IW'(1);
                  tx_data <= pay_nxt;
               end
            end
            CRC: if (xfer) begin
               tx_valid <= 1'b0;
               tx_last  <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_crc_frame_tx.sv
// tb_crc_frame_tx: queue-based frame model checked every cycle, plus directed frames with literal expectations.
module tb_crc_frame_tx;
   localparam int N = 6;
   logic clk = 0, rst_n = 0, crc_done = 0, tx_ready = 1;
   logic [7:0] crc_in = '0;
   logic [8*N-1:0] bytes_flat = '0;
   logic tx_valid, tx_last, busy;
   logic [7:0] tx_data, drop_cnt;
   int checks = 0, failures = 0;
   logic [7:0] q[$], sent[$], exp_f[$];
   int phase = 0, drops = 0, n = 0;
   bit armed = 0;

   crc_frame_tx #(.N(N)) dut (
      .clk(clk), .rst_n(rst_n), .crc_done(crc_done), .crc_in(crc_in),
      .bytes_flat(bytes_flat), .tx_ready(tx_ready), .tx_valid(tx_valid),
      .tx_data(tx_data), .tx_last(tx_last), .busy(busy), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, want);
      end
   endtask

   // phase 0 idle, 1 capture, 2 sending the queued frame
   always @(posedge clk) begin
      armed = 1;
      if (!rst_n) begin
         phase = 0;
         q.delete();
         drops = 0;
      end else begin
         if (crc_done && phase != 0 && drops < 255) drops++;
         if (phase == 0) begin
            if (crc_done) begin
`ifdef FRAME_SYNC_EN
               q.push_back(8'hA5);
`endif
               for (int k = 0; k < N; k++) q.push_back(bytes_flat[8*k +: 8]);
               phase = 1;
            end
         end else if (phase == 1) begin
            q.push_back(crc_in);
            phase = 2;
         end else if (tx_ready) begin
            void'(q.pop_front());
            if (q.size() == 0) phase = 0;
         end
      end
   end

   always @(posedge clk) if (rst_n && tx_valid && tx_ready) sent.push_back(tx_data);

   always @(negedge clk) if (armed) begin
      chk("valid", 32'(tx_valid), 32'(phase == 2));
      if (phase == 2) begin
         chk("data", 32'(tx_data), 32'(q[0]));
         chk("last", 32'(tx_last), 32'(q.size() == 1));
      end else chk("last", 32'(tx_last), 0);
      chk("busy", 32'(busy), 32'(phase != 0));
      chk("drop_cnt", 32'(drop_cnt), 32'(drops));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [8*N-1:0] b, input logic [7:0] c);
      bytes_flat = b;
      crc_in = c;
      crc_done = 1;
      step();
      crc_done = 0;
   endtask

   task automatic wait_idle(output int cnt);
      cnt = 0;
      while (busy && cnt < 500) begin
         step();
         cnt++;
      end
      chk("idle_timeout", 32'(cnt < 500), 1);
   endtask

   task automatic wait_byte(input logic [7:0] b);
      int k = 0;
      while (!(tx_valid === 1'b1 && tx_data === b) && k < 50) begin
         step();
         k++;
      end
      chk("byte_timeout", 32'(k < 50), 1);
   endtask

   task automatic make_exp(input logic [7:0] first, input logic [7:0] c);
      exp_f.delete();
`ifdef FRAME_SYNC_EN
      exp_f.push_back(8'hA5);
`endif
      for (int k = 0; k < N; k++) exp_f.push_back(first + 8'(k));
      exp_f.push_back(c);
   endtask

   task automatic check_frame(input string name);
      chk({name, "_len"}, 32'(sent.size()), 32'(exp_f.size()));
      for (int i = 0; i < exp_f.size() && i < sent.size(); i++) chk(name, 32'(sent[i]), 32'(exp_f[i]));
   endtask

   initial begin
      step();
      step();
      chk("rst_valid", 32'(tx_valid), 0);
      chk("rst_data", 32'(tx_data), 0);
      chk("rst_last", 32'(tx_last), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_drop", 32'(drop_cnt), 0);
      rst_n = 1;
      step();
      // basic frame, zero-bubble, latency
      exp_f = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h5A};
`ifdef FRAME_SYNC_EN
      exp_f.push_front(8'hA5);
`endif
      sent.delete();
      start(48'h060504030201, 8'h5A);
      chk("capt_busy", 32'(busy), 1);
      chk("capt_valid", 32'(tx_valid), 0);
      step();
      chk("first_valid", 32'(tx_valid), 1);
      chk("first_data", 32'(tx_data), 32'(exp_f[0]));
      wait_idle(n);
      chk("frame_cycles", 32'(n), 32'(exp_f.size()));
      check_frame("t1");
      // backpressure on byte 0x03
      sent.delete();
      start(48'h060504030201, 8'h5A);
      wait_byte(8'h03);
      tx_ready = 0;
      repeat (3) begin
         step();
         chk("hold_valid", 32'(tx_valid), 1);
         chk("hold_data", 32'(tx_data), 8'h03);
      end
      tx_ready = 1;
      wait_idle(n);
      check_frame("t2");
      // crc_done while busy is dropped
      sent.delete();
      start(48'h060504030201, 8'h5A);
      step();
      step();
      start({N{8'hFF}}, 8'hFF);
      wait_idle(n);
      check_frame("t3");
      chk("drop1", 32'(drop_cnt), 1);
      sent.delete();
      start(48'h060504030201, 8'h5A);
      n = 0;
      while (tx_last !== 1'b1 && n < 50) begin
         step();
         n++;
      end
      crc_done = 1;
      step();
      crc_done = 0;
      chk("last_drop_busy", 32'(busy), 0);
      chk("drop2", 32'(drop_cnt), 2);
      step();
      chk("last_drop_idle", 32'(busy), 0);
      check_frame("t3b");
      start(48'h060504030201, 8'h5A);
      step();
      tx_ready = 0;
      crc_done = 1;
      repeat (300) step();
      crc_done = 0;
      chk("drop_sat", 32'(drop_cnt), 255);
      tx_ready = 1;
      wait_idle(n);
      // reset mid-frame
      sent.delete();
      start(48'h060504030201, 8'h5A);
      wait_byte(8'h03);
      step();
      rst_n = 0;
      crc_done = 1;
      step();
      rst_n = 1;
      crc_done = 0;
      chk("mid_rst_valid", 32'(tx_valid), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_drop", 32'(drop_cnt), 0);
      chk("mid_rst_data", 32'(tx_data), 0);
      step();
      chk("mid_rst_idle", 32'(busy), 0);
      chk("mid_rst_last_sent", 32'(sent[$]), 8'h03);
      sent.delete();
      start(48'h151413121110, 8'h77);
      wait_idle(n);
      make_exp(8'h10, 8'h77);
      check_frame("t4");
      // inputs change after capture
      sent.delete();
      start(48'h262524232221, 8'h3C);
      step();
      bytes_flat = 48'hDEADBEEFCAFE;
      crc_in = 8'hEE;
      wait_idle(n);
      make_exp(8'h21, 8'h3C);
      check_frame("t5");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
